// File: rtl/kmac_decode_string.sv
`default_nettype none
// ============================================================================
// Module   : kmac_decode_string
// Purpose  : Serial decoder for encode_string fields (left_encode(len) || S).
//            Define KMAC_DEC_ERR_EN to enable malformed-field detection.
// Revision : 1.0 - initial release
// ============================================================================
module kmac_decode_string #(
    parameter int MAX_LEN = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [7:0]                         in_byte,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [7:0]                         str_bytes [0:MAX_LEN-1],
    output logic [$clog2(MAX_LEN+1)-1:0]       str_len,
    output logic                               dec_done,
    output logic                               dec_err
);

    localparam int                 c_LEN_W   = $clog2(MAX_LEN+1);
    localparam logic [c_LEN_W-1:0] c_STR_MAX = c_LEN_W'(MAX_LEN);
    localparam logic [12:0]        c_MAX_LEN = 13'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_N   = 3'd1,
        LEN_VAL = 3'd2,
        PAYLOAD = 3'd3,
        DONE_ST = 3'd4,
        ERR_ST  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_n;
    logic [7:0]  r_len_cnt;
    logic [15:0] r_acc;
    logic [12:0] r_pay_cnt;

    logic        w_xfer;
    logic        w_last_len;
    logic [15:0] w_acc_nxt;
    logic [12:0] w_exp_nxt;

    assign w_xfer     = in_valid & in_ready;
    assign w_acc_nxt  = {r_acc[7:0], in_byte};
    assign w_exp_nxt  = w_acc_nxt[15:3];
    assign w_last_len = (r_len_cnt == r_n - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        dec_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = LEN_N;
            end
            LEN_N: begin
                in_ready = 1'b1;
                if (w_xfer) begin
`ifdef KMAC_DEC_ERR_EN
                    if (in_byte == 8'd0 || in_byte > 8'd2) w_state_nxt = ERR_ST;
                    else                                   w_state_nxt = LEN_VAL;
`else
                    // An empty length prefix encodes a zero-bit string
                    if (in_byte == 8'd0) w_state_nxt = DONE_ST;
                    else                 w_state_nxt = LEN_VAL;
`endif
                end
            end
            LEN_VAL: begin
                in_ready = 1'b1;
                if (w_xfer && w_last_len) begin
`ifdef KMAC_DEC_ERR_EN
                    if (w_acc_nxt[2:0] != 3'd0)      w_state_nxt = ERR_ST;
                    else if (w_exp_nxt > c_MAX_LEN)  w_state_nxt = ERR_ST;
                    else if (w_exp_nxt == 13'd0)     w_state_nxt = DONE_ST;
                    else                             w_state_nxt = PAYLOAD;
`else
                    if (w_exp_nxt == 13'd0) w_state_nxt = DONE_ST;
                    else                    w_state_nxt = PAYLOAD;
`endif
                end
            end
            PAYLOAD: begin
                in_ready = 1'b1;
                if (w_xfer && r_pay_cnt == r_acc[15:3] - 13'd1) w_state_nxt = DONE_ST;
            end
            DONE_ST: begin
                dec_done    = 1'b1;
                w_state_nxt = IDLE;
            end
            ERR_ST: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef KMAC_DEC_ERR_EN
    assign dec_err = (r_state == ERR_ST);
`else
    assign dec_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n       <= 8'd0;
            r_len_cnt <= 8'd0;
            r_acc     <= 16'd0;
            r_pay_cnt <= 13'd0;
            str_len   <= '0;
            for (int k = 0; k < MAX_LEN; k++) str_bytes[k] <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len_cnt <= 8'd0;
                        r_acc     <= 16'd0;
                        r_pay_cnt <= 13'd0;
                        str_len   <= '0;
                        for (int k = 0; k < MAX_LEN; k++) str_bytes[k] <= 8'd0;
                    end
                end
                LEN_N: begin
                    if (w_xfer) r_n <= in_byte;
                end
                LEN_VAL: begin
                    if (w_xfer) begin
                        r_acc     <= w_acc_nxt;
                        r_len_cnt <= r_len_cnt + 8'd1;
                    end
                end
                PAYLOAD: begin
                    // Bytes past MAX_LEN match no slot and are dropped
                    if (w_xfer) begin
                        r_pay_cnt <= r_pay_cnt + 13'd1;
                        for (int k = 0; k < MAX_LEN; k++) begin
                            if (str_len == c_LEN_W'(k)) str_bytes[k] <= in_byte;
                        end
                        if (str_len != c_STR_MAX) str_len <= str_len + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kmac_decode_string.sv
`default_nettype none
// ============================================================================
// Module   : tb_kmac_decode_string
// Purpose  : Directed self-checking bench for kmac_decode_string.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kmac_decode_string;

    localparam int MAX_LEN = 32;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] str_bytes [0:MAX_LEN-1];
    logic [5:0] str_len;
    logic       dec_done;
    logic       dec_err;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    kmac_decode_string #(.MAX_LEN(MAX_LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .str_bytes(str_bytes),
        .str_len  (str_len),
        .dec_done (dec_done),
        .dec_err  (dec_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dec_done === 1'b1) done_cnt++;
        if (dec_err === 1'b1)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) chk("send_timeout", 32'(t), 32'd0);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int d0;
        int e0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_byte  = 8'h00;
        in_valid = 1'b0;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", dec_done, 0);
        chk("rst_err", dec_err, 0);
        chk("rst_len", str_len, 0);
        chk("rst_byte0", str_bytes[0], 0);
        rst_n = 1'b1;
        step();

        // Basic three-byte string, start held high mid-decode must be ignored
        d0 = done_cnt;
        do_start();
        chk("lenn_ready", in_ready, 1);
        send(8'h01);
        send(8'h18);
        send(8'h41);
        start = 1'b1;
        send(8'h42);
        start = 1'b0;
        send(8'h43);
        chk("abc_done", dec_done, 1);
        chk("abc_len", str_len, 3);
        chk("abc_b0", str_bytes[0], 8'h41);
        chk("abc_b1", str_bytes[1], 8'h42);
        chk("abc_b2", str_bytes[2], 8'h43);
        chk("abc_ready_low", in_ready, 0);
        step();
        chk("abc_done_pulse", dec_done, 0);
        chk("abc_len_hold", str_len, 3);
        step();
        chk("abc_done_count", 32'(done_cnt - d0), 1);

        // Zero-length string
        do_start();
        send(8'h01);
        send(8'h00);
        chk("empty_done", dec_done, 1);
        chk("empty_len", str_len, 0);
        chk("empty_b0_cleared", str_bytes[0], 0);
        chk("empty_ready", in_ready, 0);
        step();

        // Full 32-byte string with a 3-cycle stall mid-payload
        d0 = done_cnt;
        do_start();
        send(8'h02);
        send(8'h01);
        send(8'h00);
        for (int i = 0; i < 16; i++) send(8'(i));
        step();
        step();
        step();
        chk("stall_len", str_len, 16);
        chk("stall_ready", in_ready, 1);
        for (int i = 16; i < 32; i++) send(8'(i));
        chk("full_done", dec_done, 1);
        chk("full_len", str_len, 32);
        for (int i = 0; i < 32; i++) chk($sformatf("full_b%0d", i), str_bytes[i], 32'(i));
        step();
        step();
        chk("full_done_count", 32'(done_cnt - d0), 1);

`ifdef KMAC_DEC_ERR_EN
        // Fractional bit length
        d0 = done_cnt;
        do_start();
        send(8'h01);
        send(8'h0C);
        chk("frac_err", dec_err, 1);
        chk("frac_no_done", dec_done, 0);
        chk("frac_ready", in_ready, 0);
        step();
        chk("frac_err_pulse", dec_err, 0);
        // Too many length bytes
        do_start();
        send(8'h03);
        chk("n3_err", dec_err, 1);
        step();
        // Zero length-byte count
        do_start();
        send(8'h00);
        chk("n0_err", dec_err, 1);
        step();
        // 33 bytes exceeds MAX_LEN
        do_start();
        send(8'h02);
        send(8'h01);
        send(8'h08);
        chk("over_err", dec_err, 1);
        step();
        chk("err_mode_no_done", 32'(done_cnt - d0), 0);
`else
        // Fractional bit length floors to one byte
        do_start();
        send(8'h01);
        send(8'h0C);
        send(8'h55);
        chk("frac_done", dec_done, 1);
        chk("frac_len", str_len, 1);
        chk("frac_b0", str_bytes[0], 8'h55);
        chk("frac_no_err", dec_err, 0);
        step();
        // Zero length-byte count means empty string
        do_start();
        send(8'h00);
        chk("n0_done", dec_done, 1);
        chk("n0_len", str_len, 0);
        step();
        // 33 bytes: last one discarded, length saturates
        do_start();
        send(8'h02);
        send(8'h01);
        send(8'h08);
        for (int i = 0; i < 33; i++) send(8'(i) ^ 8'h5A);
        chk("sat_done", dec_done, 1);
        chk("sat_len", str_len, 32);
        chk("sat_b31", str_bytes[31], 8'd31 ^ 8'h5A);
        chk("sat_b0", str_bytes[0], 8'h5A);
        step();
        chk("no_err_total", 32'(err_cnt), 0);
`endif

        // Reset mid-payload, then a clean decode
        do_start();
        send(8'h01);
        send(8'h18);
        send(8'h41);
        send(8'h42);
        d0 = done_cnt;
        e0 = err_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_len", str_len, 0);
        chk("mid_rst_b0", str_bytes[0], 0);
        chk("mid_rst_done", dec_done, 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("mid_rst_no_done", 32'(done_cnt - d0), 0);
        chk("mid_rst_no_err", 32'(err_cnt - e0), 0);
        chk("mid_rst_idle", in_ready, 0);
        do_start();
        send(8'h01);
        send(8'h10);
        send(8'h61);
        send(8'h62);
        chk("post_rst_done", dec_done, 1);
        chk("post_rst_len", str_len, 2);
        chk("post_rst_b0", str_bytes[0], 8'h61);
        chk("post_rst_b1", str_bytes[1], 8'h62);
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
